fanfare_seq: RTL and testbench

Parametrised tune sequencer driving the complementary piezo outputs of KnightsTour. It generalises the fixed charge fanfare into a ROM of three selectable tunes with a scalable tempo, a clean abort path and explicit start/done handshakes. Move control issues `go` when a fanfare move completes; the piezo pins are driven only while a tune plays.

---
 rtl/fanfare_seq.sv | 209 ++++++++++++++++++++
 tb/tb_fanfare_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fanfare_seq.sv
// fanfare_seq -- tune sequencer for the complementary piezo outputs.
//
// Plays one of three tunes from a note ROM of {period, duration, last}
// entries. Durations are scaled by TEMPO_SHIFT (floored at one cycle);
// periods are never scaled. A period of 0 is a silent note.
//
// Parameters:
//   TEMPO_SHIFT  right shift applied to every note duration
//   PER_W        note-period counter width (clk cycles)
//   DUR_W        note-duration counter width (clk cycles)
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   go        in   start pulse, sampled only while idle
//   tune_sel  in   tune select with go: 0 charge, 1 error, 2 beep, 3 reserved
//   stop      in   abort request, honoured in any state (wins over go)
//   loop      in   (FANFARE_LOOP_EN only) repeat the tune until stop/rst
//   busy      out  high while a tune plays
//   done      out  one-cycle pulse on normal tune completion
//   piezo     out  square-wave tone
//   piezo_n   out  complement of piezo while a tone sounds, else 0
// Optional build macro: FANFARE_LOOP_EN adds the loop port.

module fanfare_seq #(
  parameter int unsigned TEMPO_SHIFT = 0,
  parameter int unsigned PER_W       = 15,
  parameter int unsigned DUR_W       = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] tune_sel,
  input  logic       stop,
`ifdef FANFARE_LOOP_EN
  input  logic       loop,
`endif
  output logic       busy,
  output logic       done,
  output logic       piezo,
  output logic       piezo_n
);

  typedef enum logic {IDLE, PLAY} state_t;

  typedef struct packed {
    logic [PER_W-1:0] per;
    logic [DUR_W-1:0] dur;
    logic             last;
  } note_t;

  localparam logic [PER_W-1:0] P_REST = '0;
  localparam logic [PER_W-1:0] P_G6   = PER_W'(31888);
  localparam logic [PER_W-1:0] P_C7   = PER_W'(23889);
  localparam logic [PER_W-1:0] P_E7   = PER_W'(18961);
  localparam logic [PER_W-1:0] P_G7   = PER_W'(15944);

  localparam logic [DUR_W-1:0] D_22   = DUR_W'(4194304);   // 2^22
  localparam logic [DUR_W-1:0] D_23   = DUR_W'(8388608);   // 2^23
  localparam logic [DUR_W-1:0] D_2322 = DUR_W'(12582912);  // 2^23 + 2^22
  localparam logic [DUR_W-1:0] D_24   = DUR_W'(16777216);  // 2^24

  localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);
  localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

  // ROM layout: charge 0..5, error 6..8, beep 9.
  function automatic note_t note_at(input logic [3:0] i);
    case (i)
      4'd0:    return '{P_G6,   D_23,   1'b0};
      4'd1:    return '{P_C7,   D_23,   1'b0};
      4'd2:    return '{P_E7,   D_23,   1'b0};
      4'd3:    return '{P_G7,   D_2322, 1'b0};
      4'd4:    return '{P_E7,   D_22,   1'b0};
      4'd5:    return '{P_G7,   D_24,   1'b1};
      4'd6:    return '{P_C7,   D_22,   1'b0};
      4'd7:    return '{P_REST, D_22,   1'b0};
      4'd8:    return '{P_C7,   D_22,   1'b1};
      4'd9:    return '{P_C7,   D_22,   1'b1};
      default: return '{P_REST, DUR_ONE, 1'b1};
    endcase
  endfunction

  function automatic logic [PER_W-1:0] per_of(input logic [3:0] i);
    note_t n;
    n = note_at(i);
    return n.per;
  endfunction

  function automatic logic [3:0] start_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return 4'd0;
      2'd1:    return 4'd6;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
    logic [DUR_W-1:0] s;
    s = d >> TEMPO_SHIFT;
    return (s == '0) ? DUR_ONE : s;
  endfunction

  function automatic logic tone_hi(input logic [PER_W-1:0] per,
                                   input logic [PER_W-1:0] w);
    return (per != '0) && (w < (per >> 1));
  endfunction

  function automatic logic tone_lo(input logic [PER_W-1:0] per,
                                   input logic [PER_W-1:0] w);
    return (per != '0) && !(w < (per >> 1));
  endfunction

  state_t           state;
  logic [3:0]       idx;
  logic [3:0]       start_idx;
  logic [PER_W-1:0] wcnt;
  logic [DUR_W-1:0] dcnt;
  logic             loop_q;

  note_t            cur;
  logic             note_end;
  logic [PER_W-1:0] wnext;
  logic [3:0]       nidx;
  logic [PER_W-1:0] nper;
  logic [3:0]       first_idx;
  logic [PER_W-1:0] first_per;
  logic             accept;

  always_comb begin
    cur       = note_at(idx);
    note_end  = (dcnt == eff_dur(cur.dur) - DUR_ONE);
    wnext     = (cur.per == '0 || wcnt == cur.per - PER_ONE) ? '0 : wcnt + PER_ONE;
    nidx      = cur.last ? start_idx : idx + 4'd1;
    nper      = per_of(nidx);
    first_idx = start_of(tune_sel);
    first_per = per_of(first_idx);
    accept    = go && !stop && (tune_sel != 2'd3);
  end

`ifndef FANFARE_LOOP_EN
  assign loop_q = 1'b0;
`endif

  // Outputs are registered from the next-cycle counter values so that a
  // note's first cycle already shows its high phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      start_idx <= '0;
      wcnt      <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      piezo     <= 1'b0;
      piezo_n   <= 1'b0;
`ifdef FANFARE_LOOP_EN
      loop_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= PLAY;
            idx       <= first_idx;
            start_idx <= first_idx;
            wcnt      <= '0;
            dcnt      <= '0;
            busy      <= 1'b1;
            piezo     <= tone_hi(first_per, '0);
            piezo_n   <= tone_lo(first_per, '0);
`ifdef FANFARE_LOOP_EN
            loop_q    <= loop;
`endif
          end
        end
        PLAY: begin
          if (stop) begin
            state   <= IDLE;
            busy    <= 1'b0;
            piezo   <= 1'b0;
            piezo_n <= 1'b0;
          end else if (note_end) begin
            if (cur.last && !loop_q) begin
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              piezo   <= 1'b0;
              piezo_n <= 1'b0;
            end else begin
              idx     <= nidx;
              wcnt    <= '0;
              dcnt    <= '0;
              piezo   <= tone_hi(nper, '0);
              piezo_n <= tone_lo(nper, '0);
            end
          end else begin
            dcnt    <= dcnt + DUR_ONE;
            wcnt    <= wnext;
            piezo   <= tone_hi(cur.per, wnext);
            piezo_n <= tone_lo(cur.per, wnext);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fanfare_seq.sv
// tb_fanfare_seq -- three fanfare_seq instances (TEMPO_SHIFT 8, 13, 30)
// driven by shared stimulus and compared every cycle against a note-list
// reference model, plus table-driven latency vectors and hand sequences.
module tb_fanfare_seq;

  logic       clk = 1'b0;
  logic       rst, go, stop;
  logic [1:0] tune_sel;
`ifdef FANFARE_LOOP_EN
  logic       loop;
`endif
  logic [2:0] busy_v, done_v, piezo_v, pzn_v;

  always #5 clk = ~clk;

  fanfare_seq #(.TEMPO_SHIFT(8)) u8 (
    .clk(clk), .rst(rst), .go(go), .tune_sel(tune_sel), .stop(stop),
`ifdef FANFARE_LOOP_EN
    .loop(loop),
`endif
    .busy(busy_v[0]), .done(done_v[0]), .piezo(piezo_v[0]), .piezo_n(pzn_v[0]));

  fanfare_seq #(.TEMPO_SHIFT(13)) u13 (
    .clk(clk), .rst(rst), .go(go), .tune_sel(tune_sel), .stop(stop),
`ifdef FANFARE_LOOP_EN
    .loop(loop),
`endif
    .busy(busy_v[1]), .done(done_v[1]), .piezo(piezo_v[1]), .piezo_n(pzn_v[1]));

  fanfare_seq #(.TEMPO_SHIFT(30)) u30 (
    .clk(clk), .rst(rst), .go(go), .tune_sel(tune_sel), .stop(stop),
`ifdef FANFARE_LOOP_EN
    .loop(loop),
`endif
    .busy(busy_v[2]), .done(done_v[2]), .piezo(piezo_v[2]), .piezo_n(pzn_v[2]));

  // Tunes as note lists: periods and unscaled durations.
  localparam int SH [3] = '{8, 13, 30};
  localparam int PER_T [3][6] = '{'{31888, 23889, 18961, 15944, 18961, 15944},
                                  '{23889, 0, 23889, 0, 0, 0},
                                  '{23889, 0, 0, 0, 0, 0}};
  localparam int DUR_T [3][6] = '{'{8388608, 8388608, 8388608, 12582912, 4194304, 16777216},
                                  '{4194304, 4194304, 4194304, 0, 0, 0},
                                  '{4194304, 0, 0, 0, 0, 0}};
  localparam int LEN [3] = '{6, 3, 1};

  int   vecs = 0;
  int   bad  = 0;

  logic m_play [3];
  logic m_done [3];
  logic m_lp   [3];
  int   m_tn   [3];
  int   m_nt   [3];
  int   m_t    [3];

  function automatic int eff(int d, int dur);
    int s;
    s = dur >> SH[d];
    return (s == 0) ? 1 : s;
  endfunction

  // Reference: which note is sounding and how many cycles into it.
  task automatic step();
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_play[d] = 1'b0;
        m_done[d] = 1'b0;
      end else begin
        m_done[d] = 1'b0;
        if (!m_play[d]) begin
          if (go && !stop && tune_sel != 2'd3) begin
            m_play[d] = 1'b1;
            m_tn[d]   = int'(tune_sel);
            m_nt[d]   = 0;
            m_t[d]    = 0;
`ifdef FANFARE_LOOP_EN
            m_lp[d]   = loop;
`else
            m_lp[d]   = 1'b0;
`endif
          end
        end else if (stop) begin
          m_play[d] = 1'b0;
        end else begin
          m_t[d]++;
          if (m_t[d] == eff(d, DUR_T[m_tn[d]][m_nt[d]])) begin
            m_t[d] = 0;
            if (m_nt[d] == LEN[m_tn[d]] - 1) begin
              if (m_lp[d]) m_nt[d] = 0;
              else begin
                m_play[d] = 1'b0;
                m_done[d] = 1'b1;
              end
            end else begin
              m_nt[d]++;
            end
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    int per;
    logic epz, epn;
    logic [3:0] ex, ac;
    for (int d = 0; d < 3; d++) begin
      per = m_play[d] ? PER_T[m_tn[d]][m_nt[d]] : 0;
      epz = (per != 0) && ((m_t[d] % (per == 0 ? 1 : per)) < per / 2);
      epn = (per != 0) && !epz;
      ex  = {m_play[d], m_done[d], epz, epn};
      ac  = {busy_v[d], done_v[d], piezo_v[d], pzn_v[d]};
      vecs++;
      if (ac !== ex) begin
        bad++;
        $display("FAIL model_d%0d t=%0t: busy/done/piezo/piezo_n got %b expected %b",
                 d, $time, ac, ex);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic check(string name, int act, int exp);
    vecs++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] sel;
    logic       stp;
    int         lat13;
    int         lat30;
  } vec_t;

  vec_t tab [5];
  int   got13, got30, sil, hi, lo, got;

  initial begin
    // latency = 1 + sum of effective durations; -1 = start must be ignored
    tab[0] = '{2'd0, 1'b0, 7169, 7};
    tab[1] = '{2'd1, 1'b0, 1537, 4};
    tab[2] = '{2'd2, 1'b0, 513, 2};
    tab[3] = '{2'd3, 1'b0, -1, -1};
    tab[4] = '{2'd2, 1'b1, -1, -1};

    for (int d = 0; d < 3; d++) begin
      m_play[d] = 1'b0; m_done[d] = 1'b0; m_lp[d] = 1'b0;
      m_tn[d] = 0; m_nt[d] = 0; m_t[d] = 0;
    end
    rst = 1'b1; go = 1'b0; stop = 1'b0; tune_sel = 2'd0;
`ifdef FANFARE_LOOP_EN
    loop = 1'b0;
`endif
    @(negedge clk);
    run(3);
    check("reset_outputs", int'({busy_v, done_v, piezo_v, pzn_v}), 0);
    rst = 1'b0;
    cyc();

    // reserved tune select
    go = 1'b1; tune_sel = 2'd3; cyc(); go = 1'b0;
    run(10);
    check("sel3_busy", int'(busy_v), 0);

    // table: tune latencies on the short-tempo instances
    for (int i = 0; i < 5; i++) begin
      go = 1'b1; tune_sel = tab[i].sel; stop = tab[i].stp;
      cyc();
      go = 1'b0; stop = 1'b0;
      got13 = -1; got30 = -1; sil = 0;
      for (int k = 1; k <= 9000; k++) begin
        if (done_v[1] && got13 < 0) got13 = k;
        if (done_v[2] && got30 < 0) got30 = k;
        if (k >= 513 && k <= 1024 && (piezo_v[1] || pzn_v[1])) sil++;
        if (got13 >= 0 || (tab[i].lat13 < 0 && k >= 10)) break;
        cyc();
      end
      if (tab[i].lat13 < 0) check($sformatf("vec%0d_ignored_busy", i), int'(busy_v), 0);
      check($sformatf("vec%0d_lat13", i), got13, tab[i].lat13);
      check($sformatf("vec%0d_lat30", i), got30, tab[i].lat30);
      if (tab[i].sel == 2'd1) check("tune1_silent_window", sil, 0);
      stop = 1'b1; cyc(); stop = 1'b0; cyc();
    end

    // go reasserted mid-tune does not move the done time
    go = 1'b1; tune_sel = 2'd0; cyc(); go = 1'b0;
    run(99);
    go = 1'b1; tune_sel = 2'd1; cyc(); go = 1'b0;
    got = -1;
    for (int k = 101; k <= 9000; k++) begin
      if (done_v[1]) begin got = k; break; end
      cyc();
    end
    check("rego_done_lat13", got, 7169);
    stop = 1'b1; cyc(); stop = 1'b0; cyc();

    // charge at tempo 8: first period high/low halves, then reset mid-tune
    go = 1'b1; tune_sel = 2'd0; cyc(); go = 1'b0;
    check("busy_rise", int'(busy_v[0]), 1);
    hi = 0;
    while (piezo_v[0] && !pzn_v[0] && hi < 40000) begin hi++; cyc(); end
    lo = 0;
    while (!piezo_v[0] && pzn_v[0] && lo < 40000) begin lo++; cyc(); end
    check("g6_high_half", hi, 15944);
    check("g6_low_half", lo, 15944);
    go = 1'b1; tune_sel = 2'd2; cyc(); go = 1'b0;
    run(100);
    check("regen_still_busy", int'(busy_v[0]), 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    check("rst_clear", int'({busy_v, done_v, piezo_v, pzn_v}), 0);
    cyc();

    // beep stopped after 5000 cycles, restarted the next cycle
    go = 1'b1; tune_sel = 2'd2; cyc(); go = 1'b0;
    run(4999);
    stop = 1'b1; cyc(); stop = 1'b0;
    check("stop_clear_d8", int'({busy_v[0], done_v[0], piezo_v[0], pzn_v[0]}), 0);
    go = 1'b1; tune_sel = 2'd2; cyc(); go = 1'b0;
    got = -1;
    for (int k = 1; k <= 20000; k++) begin
      if (done_v[0]) begin got = k; break; end
      cyc();
    end
    check("beep_restart_lat8", got, 16385);
    cyc();
    check("after_done_quiet", int'(piezo_v[0] | pzn_v[0]), 0);

`ifdef FANFARE_LOOP_EN
    loop = 1'b1; go = 1'b1; tune_sel = 2'd2; cyc(); go = 1'b0; loop = 1'b0;
    run(1500);
    check("loop_busy13", int'(busy_v[1]), 1);
    stop = 1'b1; cyc(); stop = 1'b0;
    check("loop_stopped", int'(busy_v), 0);
    cyc();
`endif

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      go       = ($urandom % 6) == 0;
      tune_sel = 2'($urandom % 4);
      stop     = ($urandom % 200) == 0;
      rst      = ($urandom % 1500) == 0;
      cyc();
    end
    go = 1'b0; stop = 1'b0; rst = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
